// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one MUX-based full-adder cell, LSB first, WIDTH+1 cycles per op.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.

module fa_mux (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic p;

  assign p    = a ^ b;
  // Propagate selects between inverted/true propagate for sum, and between cin/a for carry.
  assign s    = cin ? ~p : p;
  assign cout = p ? cin : a;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             overflow,
`endif
  output logic             cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sr_reg, b_sr_reg, acc_reg, sum_reg;
  logic             carry_reg, cout_reg;
  logic [CW-1:0]    cnt_reg;
  logic             bit_s, bit_c, last_bit;

  fa_mux u_fa (
    .a    (a_sr_reg[0]),
    .b    (b_sr_reg[0]),
    .cin  (carry_reg),
    .s    (bit_s),
    .cout (bit_c)
  );

  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_reg  <= '0;
      b_sr_reg  <= '0;
      acc_reg   <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1, so the incoming cin is replaced by 1.
            a_sr_reg  <= a_in;
            b_sr_reg  <= sub ? ~b_in : b_in;
            carry_reg <= sub ? 1'b1 : cin;
            cnt_reg   <= '0;
            acc_reg   <= '0;
          end
        end
        RUN: begin
          a_sr_reg  <= {1'b0, a_sr_reg[WIDTH-1:1]};
          b_sr_reg  <= {1'b0, b_sr_reg[WIDTH-1:1]};
          acc_reg   <= {bit_s, acc_reg[WIDTH-1:1]};
          carry_reg <= bit_c;
          cnt_reg   <= cnt_reg + CW'(1);
          if (last_bit) begin
            sum_reg  <= {bit_s, acc_reg[WIDTH-1:1]};
            cout_reg <= bit_c;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_reg;

  // On the last bit carry_reg is the carry into the MSB and bit_c the carry out of it.
  always_ff @(posedge clk) begin
    if (rst)                             ovf_reg <= 1'b0;
    else if (state_reg == RUN && last_bit) ovf_reg <= carry_reg ^ bit_c;
  end

  assign overflow = ovf_reg;
`endif

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed-vector bench for serial_adder_ctrl (WIDTH=8): results, latency, done pulse, ignored start, reset mid-run.
// Overflow checks are active when SERIAL_ADDER_OVF_EN is defined.

module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, sub, cin;
  logic [W-1:0] a_in, b_in;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic         overflow;
`endif

  int tests = 0;
  int fails = 0;
  logic [W-1:0] prev_sum;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic         s;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs [9];

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
`ifdef SERIAL_ADDER_OVF_EN
    .overflow (overflow),
`endif
    .cout     (cout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  // Launches one operation and watches W+4 cycles; optionally pulses a rogue start at glitch_at.
  task automatic do_op(input vec_t v, input int glitch_at);
    int busy_cnt, done_cnt, done_idx;
    busy_cnt = 0; done_cnt = 0; done_idx = -1;
    @(negedge clk);
    a_in = v.a; b_in = v.b; cin = v.c; sub = v.s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_in = ~v.a; b_in = v.a; cin = ~v.c; sub = ~v.s;
    for (int n = 0; n < W + 4; n++) begin
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_idx = n; end
      if (n == W - 1) chk("sum_held_during_run", sum, prev_sum);
      if (n == glitch_at) begin
        start = 1'b1; a_in = 8'h01; b_in = 8'h01; sub = 1'b0; cin = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("sum", sum, v.exp_sum);
    chk("cout", cout, v.exp_cout);
`ifdef SERIAL_ADDER_OVF_EN
    chk("overflow", overflow, v.exp_ovf);
`endif
    chk("busy_cycles", busy_cnt, W + 1);
    chk("done_pulses", done_cnt, 1);
    chk("done_latency", done_idx, W);
    $display("[TB] op a=%02h b=%02h cin=%0b sub=%0b -> sum=%02h cout=%0b busy=%0d done@%0d",
             v.a, v.b, v.c, v.s, sum, cout, busy_cnt, done_idx);
    prev_sum = v.exp_sum;
  endtask

  initial begin
    vecs[0] = '{8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[3] = '{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0};
    vecs[4] = '{8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[6] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[7] = '{8'h05, 8'h05, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[8] = '{8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a_in = '0; b_in = '0;
    prev_sum = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_sum", sum, 8'h00);
    chk("reset_cout", cout, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("reset_overflow", overflow, 1'b0);
`endif

    for (int i = 0; i < 9; i++) do_op(vecs[i], -1);

    // Rogue start 3 cycles into RUN must be ignored.
    do_op(vecs[0], 3);

    // Reset 4 cycles into RUN discards the operation and clears the result.
    @(negedge clk);
    a_in = 8'h35; b_in = 8'h4A; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun_rst_busy", busy, 1'b0);
    chk("midrun_rst_done", done, 1'b0);
    chk("midrun_rst_sum", sum, 8'h00);
    chk("midrun_rst_cout", cout, 1'b0);
    $display("[TB] reset mid-run -> busy=%0b done=%0b sum=%02h cout=%0b", busy, done, sum, cout);
    repeat (W + 2) @(negedge clk);
    chk("post_rst_no_done", done, 1'b0);
    prev_sum = '0;
    do_op('{8'h22, 8'h11, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0}, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
